// File: rtl/stream_demux_rr_pkg.sv
// Shared encodings and helpers for the round-robin / direct stream demultiplexer.
package stream_demux_rr_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_rr_slot.sv
// Single-entry registered holding slot: load wins over drain so a same-cycle
// drain and refill keeps the slot full with the new data.
module demux_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] load_data,
  output logic          full,
  output logic [DW-1:0] data
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/stream_demux_rr.sv
// 1-to-N stream demux, DIRECT or round-robin steering, with a RUN/DRAIN FSM for
// mode changes. Optional STREAM_DEMUX_BEAT_CNT_EN adds a saturating beat counter.
module stream_demux_rr
  import stream_demux_rr_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int SW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic [SW-1:0]       in_sel,
  input  logic                mode_req,
  output logic                mode,
  output logic [N_OUT-1:0]    out_valid,
  input  logic [N_OUT-1:0]    out_ready,
  output logic [N_OUT*DW-1:0] out_data,
  output logic [SW-1:0]       rr_ptr,
  output logic                busy
`ifdef STREAM_DEMUX_BEAT_CNT_EN
  , output logic [15:0]       beat_cnt
`endif
);

  if (SW != clog2(N_OUT)) begin : g_sw_chk
    $error("SW must equal clog2(N_OUT)");
  end

  logic [0:0]                 state_q, state_d;
  logic                       mode_q, mode_d;
  logic [SW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [N_OUT-1:0]           full, load, drain;
  logic [N_OUT-1:0][DW-1:0]   slot_data;
  logic [SW-1:0]              tgt;
  logic                       tgt_ok, full_tgt, ordy_tgt, accept, drain_done;

  assign tgt = (mode_q == MODE_RR) ? rr_ptr_q : in_sel;

  // Selects beyond N_OUT-1 match no slot, so tgt_ok stays low and the beat stalls.
  always_comb begin
    tgt_ok   = 1'b0;
    full_tgt = 1'b0;
    ordy_tgt = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (tgt == SW'(k)) begin
        tgt_ok   = 1'b1;
        full_tgt = full[k];
        ordy_tgt = out_ready[k];
      end
    end
  end

  assign in_ready = rst_n && (state_q == ST_RUN) && tgt_ok && (!full_tgt || ordy_tgt);
  assign accept   = in_valid && in_ready;
  assign drain    = full & out_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) load[k] = accept && (tgt == SW'(k));
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .drain     (drain[k]),
      .load_data (in_data),
      .full      (full[k]),
      .data      (slot_data[k])
    );
  end

  assign drain_done = (state_q == ST_DRAIN) && (full == '0);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode_q == MODE_RR))
      rr_ptr_d = (rr_ptr_q == SW'(N_OUT - 1)) ? '0 : rr_ptr_q + SW'(1);
    case (state_q)
      ST_RUN:   if (mode_req != mode_q) state_d = ST_DRAIN;
      default: begin
        if (drain_done) begin
          state_d  = ST_RUN;
          mode_d   = mode_req;
          rr_ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      mode_q   <= MODE_DIRECT;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef STREAM_DEMUX_BEAT_CNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (drain_done)
      beat_cnt_d = '0;
    else if (accept && (beat_cnt_q != 16'hFFFF))
      beat_cnt_d = beat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`endif

  assign mode      = mode_q;
  assign rr_ptr    = rr_ptr_q;
  assign busy      = (state_q == ST_DRAIN);
  assign out_valid = full;
  assign out_data  = slot_data;

endmodule

// File: tb/tb_stream_demux_rr.sv
// Directed, table-driven bench for stream_demux_rr (N_OUT=4) plus an N_OUT=3
// instance for the out-of-range select case.
module tb_stream_demux_rr;

  logic        clk, rst_n;
  logic        in_valid, in_ready, mode_req, mode, busy;
  logic [7:0]  in_data;
  logic [1:0]  in_sel, rr_ptr;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;

  logic        iv3, rdy3, mreq3, mode3, busy3;
  logic [7:0]  d3;
  logic [1:0]  sel3, ptr3;
  logic [2:0]  ov3, ordy3;
  logic [23:0] od3;
`ifdef STREAM_DEMUX_BEAT_CNT_EN
  logic [15:0] beat_cnt, beat_cnt3;
`endif

  stream_demux_rr #(.N_OUT(4), .DW(8), .SW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .mode_req(mode_req), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rr_ptr(rr_ptr), .busy(busy)
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  stream_demux_rr #(.N_OUT(3), .DW(8), .SW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(rdy3),
    .in_data(d3), .in_sel(sel3), .mode_req(mreq3), .mode(mode3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
    .rr_ptr(ptr3), .busy(busy3)
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    , .beat_cnt(beat_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [7:0] d;
    logic       mreq;
    logic [3:0] ordy;
    logic       e_rdy;
    logic [3:0] e_ov;
    logic [1:0] e_ptr;
    logic       e_mode;
    logic       e_busy;
    int         ch;
    logic [7:0] e_d;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [1:0] sel, input logic [7:0] d,
                     input logic mreq, input logic [3:0] ordy, input logic e_rdy,
                     input logic [3:0] e_ov, input logic [1:0] e_ptr, input logic e_mode,
                     input logic e_busy, input int ch, input logic [7:0] e_d);
    vec_t v;
    v.iv = iv; v.sel = sel; v.d = d; v.mreq = mreq; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ptr = e_ptr; v.e_mode = e_mode;
    v.e_busy = e_busy; v.ch = ch; v.e_d = e_d;
    vq.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; mode_req = 1'b0; out_ready = '0;
    iv3 = 1'b0; d3 = '0; sel3 = '0; mreq3 = 1'b0; ordy3 = '0;

    //   iv sel d      mreq ordy     rdy ov       ptr mode busy ch  data
    add(1, 2, 8'hA5, 0, 4'b0000, 1, 4'b0100, 0, 0, 0,  2, 8'hA5);  // DIRECT to ch2
    add(1, 2, 8'hB6, 0, 4'b0000, 0, 4'b0100, 0, 0, 0,  2, 8'hA5);  // ch2 full: stall, hold
    add(1, 2, 8'hB6, 0, 4'b0100, 1, 4'b0100, 0, 0, 0,  2, 8'hB6);  // drain+refill ch2
    add(0, 2, 8'h00, 0, 4'b0100, 1, 4'b0000, 0, 0, 0, -1, 8'h00);
    add(1, 0, 8'h11, 0, 4'b0000, 1, 4'b0001, 0, 0, 0,  0, 8'h11);
    add(1, 0, 8'h22, 0, 4'b0001, 1, 4'b0001, 0, 0, 0,  0, 8'h22);  // back-to-back ch0
    add(1, 1, 8'h33, 0, 4'b0000, 1, 4'b0011, 0, 0, 0,  1, 8'h33);
    add(1, 3, 8'h44, 0, 4'b0001, 1, 4'b1010, 0, 0, 0,  3, 8'h44);
    add(0, 0, 8'h00, 1, 4'b0000, 1, 4'b1010, 0, 0, 1,  1, 8'h33);  // request RR -> DRAIN
    add(1, 0, 8'h55, 1, 4'b0000, 0, 4'b1010, 0, 0, 1,  3, 8'h44);
    add(0, 0, 8'h00, 1, 4'b0010, 0, 4'b1000, 0, 0, 1, -1, 8'h00);
    add(0, 0, 8'h00, 1, 4'b1000, 0, 4'b0000, 0, 0, 1, -1, 8'h00);
    add(0, 0, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 1, 0, -1, 8'h00);  // DRAIN -> RUN in RR
    add(1, 0, 8'h10, 1, 4'b1111, 1, 4'b0001, 1, 1, 0,  0, 8'h10);  // RR wrap sequence
    add(1, 0, 8'h11, 1, 4'b1111, 1, 4'b0010, 2, 1, 0,  1, 8'h11);
    add(1, 0, 8'h12, 1, 4'b1111, 1, 4'b0100, 3, 1, 0,  2, 8'h12);
    add(1, 0, 8'h13, 1, 4'b1111, 1, 4'b1000, 0, 1, 0,  3, 8'h13);
    add(1, 0, 8'h14, 1, 4'b1111, 1, 4'b0001, 1, 1, 0,  0, 8'h14);
    add(1, 0, 8'h15, 1, 4'b1111, 1, 4'b0010, 2, 1, 0,  1, 8'h15);
    add(0, 0, 8'h00, 1, 4'b1111, 1, 4'b0000, 2, 1, 0, -1, 8'h00);
    add(1, 0, 8'h66, 0, 4'b0000, 1, 4'b0100, 3, 1, 1,  2, 8'h66);  // beat completes on DRAIN entry
    add(0, 0, 8'h00, 1, 4'b0000, 0, 4'b0100, 3, 1, 1, -1, 8'h00);  // request bounces back
    add(0, 0, 8'h00, 1, 4'b0100, 0, 4'b0000, 3, 1, 1, -1, 8'h00);
    add(0, 0, 8'h00, 1, 4'b0000, 0, 4'b0000, 0, 1, 0, -1, 8'h00);  // mode kept, ptr cleared
    add(1, 0, 8'h70, 1, 4'b0101, 1, 4'b0001, 1, 1, 0,  0, 8'h70);  // fill ch1/ch3 for reset
    add(1, 0, 8'h71, 1, 4'b0101, 1, 4'b0010, 2, 1, 0,  1, 8'h71);
    add(1, 0, 8'h72, 1, 4'b0101, 1, 4'b0110, 3, 1, 0,  2, 8'h72);
    add(1, 0, 8'h73, 1, 4'b0101, 1, 4'b1010, 0, 1, 0,  3, 8'h73);
    add(1, 0, 8'h74, 1, 4'b0101, 1, 4'b1011, 1, 1, 0,  0, 8'h74);
    add(0, 0, 8'h00, 1, 4'b0001, 0, 4'b1010, 1, 1, 0,  1, 8'h71);

    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst in_ready",  32'(in_ready),  32'h0);
    chk("rst rr_ptr",    32'(rr_ptr),    32'h0);
    chk("rst mode",      32'(mode),      32'h0);
    chk("rst busy",      32'(busy),      32'h0);
    chk("rst out_data",  out_data,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      in_valid = vq[i].iv; in_sel = vq[i].sel; in_data = vq[i].d;
      mode_req = vq[i].mreq; out_ready = vq[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      chk($sformatf("v%0d rr_ptr", i),    32'(rr_ptr),    32'(vq[i].e_ptr));
      chk($sformatf("v%0d mode", i),      32'(mode),      32'(vq[i].e_mode));
      chk($sformatf("v%0d busy", i),      32'(busy),      32'(vq[i].e_busy));
      if (vq[i].ch >= 0)
        chk($sformatf("v%0d out_data[%0d]", i, vq[i].ch),
            32'(out_data[vq[i].ch*8 +: 8]), 32'(vq[i].e_d));
    end
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    chk("beat_cnt after RR fill", 32'(beat_cnt), 32'd5);
`endif

    // Asynchronous reset mid-cycle with slots 1 and 3 full, rr_ptr=1, mode=RR.
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst in_ready",  32'(in_ready),  32'h0);
    chk("midrst rr_ptr",    32'(rr_ptr),    32'h0);
    chk("midrst mode",      32'(mode),      32'h0);
    chk("midrst busy",      32'(busy),      32'h0);
    chk("midrst out_data",  out_data,       32'h0);
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    chk("midrst beat_cnt",  32'(beat_cnt),  32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1; mode_req = 1'b0; in_valid = 1'b1; in_sel = 2'd0; out_ready = '0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b0;

    // Out-of-range select on the 3-channel instance never gets accepted.
    @(negedge clk);
    iv3 = 1'b1; sel3 = 2'd3; d3 = 8'h99; ordy3 = '0; mreq3 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("sel3 c%0d in_ready", c), 32'(rdy3), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("sel3 c%0d out_valid", c), 32'(ov3), 32'h0);
      @(negedge clk);
    end
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    chk("sel3 beat_cnt held", 32'(beat_cnt3), 32'h0);
`endif
    sel3 = 2'd1;
    #1;
    chk("sel1 in_ready", 32'(rdy3), 32'h1);
    @(posedge clk);
    #1;
    chk("sel1 out_valid", 32'(ov3), 32'h2);
    chk("sel1 out_data[1]", 32'(od3[15:8]), 32'h99);
`ifdef STREAM_DEMUX_BEAT_CNT_EN
    chk("sel1 beat_cnt", 32'(beat_cnt3), 32'h1);
`endif
    iv3 = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
